// File: rtl/ysyx_23060240_pkg.sv
// Shared definitions for the ysyx_23060240 fetch controller: FSM state
// encoding, the default reset PC, the sequential PC increment and a small
// alignment helper.
package ysyx_23060240_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

   // A fetch address is word aligned when its two low bits are zero.
   function automatic logic pc_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/ysyx_23060240_fetch_ctrl.sv
// ysyx_23060240_fetch_ctrl
// Single-outstanding instruction fetch controller. Issues one request at
// pc_r, waits for the word, presents it to decode and advances by 4 once it
// is consumed. A redirect from execute always wins and reloads pc_r; a
// response belonging to a request issued before the redirect is dropped.
// Optional macro YSYX_23060240_FETCH_MISALIGN_CHECK_EN: a misaligned pc_r
// skips the memory request and presents inst=0 with fetch_fault=1.
module ysyx_23060240_fetch_ctrl
   import ysyx_23060240_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        fetch_fault
);

   fetch_state_e state_r;
   fetch_state_e state_nxt_s;
   logic [31:0]  pc_r;
   logic [31:0]  inst_r;
   logic         drop_r;
   logic         misalign_s;
   logic         req_valid_s;
   logic         req_fire_s;
   logic         rsp_take_s;
   logic         consume_s;

`ifdef YSYX_23060240_FETCH_MISALIGN_CHECK_EN
   assign misalign_s = pc_misaligned(pc_r);
`else
   assign misalign_s = 1'b0;
`endif

   assign req_valid_s = (state_r == S_REQ) && !misalign_s;
   assign req_fire_s  = req_valid_s && imem_req_ready;
   assign rsp_take_s  = (state_r == S_WAIT) && imem_rsp_valid;
   assign consume_s   = (state_r == S_OUT) && inst_ready;

   // State register, returns to idle on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; a redirect never lets a stale word reach S_OUT.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            state_nxt_s = S_REQ;
         end
         S_REQ: begin
            if (misalign_s) begin
               if (redirect_valid) begin
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_OUT;
               end
            end else if (imem_req_ready) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect_valid || drop_r) begin
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_OUT;
               end
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_OUT: begin
            if (redirect_valid || inst_ready) begin
               state_nxt_s = S_REQ;
            end else begin
               state_nxt_s = S_OUT;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // PC register: redirect has priority over the sequential advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (redirect_valid) begin
         pc_r <= redirect_pc;
      end else if (consume_s) begin
         pc_r <= pc_r + PC_INCR;
      end else begin
         pc_r <= pc_r;
      end
   end

   // Instruction register: only words that will be presented are captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_r <= 32'h0;
      end else if (rsp_take_s && !redirect_valid && !drop_r) begin
         inst_r <= imem_rsp_data;
      end else if ((state_r == S_REQ) && misalign_s && !redirect_valid) begin
         inst_r <= 32'h0;
      end else begin
         inst_r <= inst_r;
      end
   end

   // Drop flag: marks an in-flight request made stale by a redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_r <= 1'b0;
      end else if (rsp_take_s) begin
         drop_r <= 1'b0;
      end else if (redirect_valid && ((state_r == S_WAIT) || req_fire_s)) begin
         drop_r <= 1'b1;
      end else begin
         drop_r <= drop_r;
      end
   end

   // Output decode, driven purely from registered state.
   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = pc_r;
      inst_valid     = 1'b0;
      inst           = inst_r;
      pc             = pc_r;
      fetch_fault    = 1'b0;
      case (state_r)
         S_REQ: begin
            imem_req_valid = req_valid_s;
         end
         S_OUT: begin
            inst_valid  = 1'b1;
            fetch_fault = misalign_s;
         end
         default: begin
            imem_req_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060240_fetch_ctrl.sv
// Directed bench for ysyx_23060240_fetch_ctrl. Expected decode-side words are
// queued when the memory response is driven and checked when inst_valid
// appears. Define YSYX_23060240_FETCH_MISALIGN_CHECK_EN to exercise the
// misaligned-PC fault path.
module tb_ysyx_23060240_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        fetch_fault;

   ysyx_23060240_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .pc             (pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a request, check its address, complete the handshake.
   task automatic req_handshake(input logic [31:0] exp_addr);
      logic found = 1'b0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk1("req_seen", found, 1'b1);
      chk32("req_addr", imem_req_addr, exp_addr);
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk1("single_outstanding", imem_req_valid, 1'b0);
   endtask

   // Drive one response beat; queue it when it should reach decode.
   task automatic respond(input logic [31:0] data, input logic [31:0] exp_pc, input logic push);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      if (push) begin
         sb_q.push_back('{inst: data, pc: exp_pc, fault: 1'b0});
      end
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
   endtask

   // Wait for inst_valid, compare against the scoreboard, stall, then consume.
   task automatic consume(input int hold, input logic redir, input logic [31:0] rpc);
      logic found = 1'b0;
      exp_t e = '0;
      for (int i = 0; i < 20; i++) begin
         if (inst_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk1("inst_valid_seen", found, 1'b1);
      chk32("sb_depth", sb_q.size(), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
      end
      chk32("inst", inst, e.inst);
      chk32("pc", pc, e.pc);
      chk1("fetch_fault", fetch_fault, e.fault);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk1("hold_valid", inst_valid, 1'b1);
         chk32("hold_inst", inst, e.inst);
         chk32("hold_pc", pc, e.pc);
         chk1("hold_no_req", imem_req_valid, 1'b0);
      end
      inst_ready = 1'b1;
      if (redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = rpc;
      end
      @(negedge clk);
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      chk1("consumed", inst_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      inst_ready     = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_fault", fetch_fault, 1'b0);
      chk32("rst_pc", pc, RST_PC);
      chk32("rst_inst", inst, 32'h0);
      rst = 1'b0;

      // Zero-wait fetch at reset PC, stalled decode, then sequential PC
      req_handshake(RST_PC);
      respond(32'h0000_0093, RST_PC, 1'b1);
      consume(5, 1'b0, 32'h0);
      req_handshake(32'h8000_0004);

      // Redirect while waiting; the late response must be dropped
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk1("drop_wait1", inst_valid, 1'b0);
      @(negedge clk);
      chk1("drop_wait2", inst_valid, 1'b0);
      respond(32'hDEAD_BEEF, 32'h0, 1'b0);
      chk1("drop_not_presented", inst_valid, 1'b0);
      req_handshake(32'h8000_0100);

      // Redirect coincident with consume: redirect target beats pc+4
      respond(32'h0010_0113, 32'h8000_0100, 1'b1);
      consume(0, 1'b1, 32'h8000_0200);
      req_handshake(32'h8000_0200);
      respond(32'h0020_0193, 32'h8000_0200, 1'b1);
      consume(0, 1'b0, 32'h0);

      // Redirect during a request handshake: that request's data is dropped
      chk1("req_before_hs_redirect", imem_req_valid, 1'b1);
      chk32("req_addr_204", imem_req_addr, 32'h8000_0204);
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      @(negedge clk);
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      respond(32'hBAD0_0001, 32'h0, 1'b0);
      chk1("hs_drop_not_presented", inst_valid, 1'b0);
      req_handshake(32'h8000_0300);
      respond(32'h0030_0213, 32'h8000_0300, 1'b1);
      consume(1, 1'b0, 32'h0);

      // Redirect in S_REQ without ready, then PC wraps past the top
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      req_handshake(32'hFFFF_FFFC);
      respond(32'h0040_0293, 32'hFFFF_FFFC, 1'b1);
      consume(0, 1'b0, 32'h0);
      req_handshake(32'h0000_0000);
      respond(32'h0050_0313, 32'h0000_0000, 1'b1);
      consume(0, 1'b0, 32'h0);

      // Reset mid-request; the late response is ignored
      req_handshake(32'h0000_0004);
      rst = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0002;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      chk1("midrst_inst_valid", inst_valid, 1'b0);
      chk1("midrst_req_valid", imem_req_valid, 1'b1);
      chk32("midrst_req_addr", imem_req_addr, RST_PC);
      req_handshake(RST_PC);
      respond(32'h0060_0393, RST_PC, 1'b1);
      consume(0, 1'b0, 32'h0);

`ifdef YSYX_23060240_FETCH_MISALIGN_CHECK_EN
      // Misaligned PC: no memory request, faulted empty instruction
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0002;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk1("misalign_no_req", imem_req_valid, 1'b0);
      sb_q.push_back('{inst: 32'h0, pc: 32'h8000_0002, fault: 1'b1});
      consume(2, 1'b1, 32'h8000_0008);
      req_handshake(32'h8000_0008);
      respond(32'h0070_0413, 32'h8000_0008, 1'b1);
      consume(0, 1'b0, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
